// File: rtl/uart_rx_fifo_param.sv
// Oversampling UART receiver feeding a first-word-fall-through receive FIFO with per-word parity/framing flags.
// Latency: last stop sample -> push +1 clk -> head visible +1 clk; no backpressure, a full FIFO drops the frame and sets overrun.
module uart_rx_fifo_param #(
    parameter int DATA_BITS  = 8,
    parameter int OVS        = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          RSTn,
    input  logic                          baud_tick,
    input  logic                          RXD,
    input  logic [1:0]                    parity_mode,
    input  logic                          rd_en,
    input  logic                          ovr_clr,
    output logic [DATA_BITS-1:0]          rx_data,
    output logic                          rx_perr,
    output logic                          rx_ferr,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_level,
    output logic                          overrun,
    output logic                          busy
);
    localparam int CW = $clog2(OVS);
    localparam int BW = $clog2(DATA_BITS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int WW = DATA_BITS + 2;

    localparam logic [CW-1:0] CNT_MID   = CW'(OVS / 2 - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(OVS - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [BW-1:0] BIT_ONE   = BW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [AW:0]   LVL_ONE   = (AW + 1)'(1);
    localparam logic [AW:0]   LVL_FULL  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, PARITY, STOP, BREAK
    } state_t;

    state_t                 r_state, w_next;
    logic                   r_rx_meta, r_rxs;
    logic [CW-1:0]          r_cnt;
    logic [BW-1:0]          r_bitcnt;
    logic                   r_par_en, r_par_odd;
    logic [DATA_BITS-1:0]   r_shift;
    logic                   r_perr, r_ferr;
    logic                   r_push;
    logic [WW-1:0]          r_word;
    logic [WW-1:0]          r_mem [FIFO_DEPTH];
    logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
    logic [AW:0]            r_level;
    logic                   r_overrun;

    logic                   w_mid, w_samp, w_stop_ferr;
    logic                   w_full, w_empty, w_pop, w_wr, w_drop;
    logic [WW-1:0]          w_head;

    assign w_mid       = baud_tick && (r_cnt == CNT_MID);
    assign w_samp      = baud_tick && (r_cnt == CNT_LAST);
    assign w_stop_ferr = r_ferr || !r_rxs;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_rx_meta <= 1'b1;
            r_rxs     <= 1'b1;
            r_state   <= IDLE;
        end else begin
            r_rx_meta <= RXD;
            r_rxs     <= r_rx_meta;
            r_state   <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (baud_tick && !r_rxs) w_next = START;
            START:   if (w_mid) w_next = r_rxs ? IDLE : DATA;
            DATA:    if (w_samp && (r_bitcnt == DATA_LAST)) w_next = r_par_en ? PARITY : STOP;
            PARITY:  if (w_samp) w_next = STOP;
            STOP:    if (w_samp && (r_bitcnt == STOP_LAST)) w_next = w_stop_ferr ? BREAK : IDLE;
            BREAK:   if (baud_tick && r_rxs) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_cnt     <= '0;
            r_bitcnt  <= '0;
            r_par_en  <= 1'b0;
            r_par_odd <= 1'b0;
            r_shift   <= '0;
            r_perr    <= 1'b0;
            r_ferr    <= 1'b0;
            r_push    <= 1'b0;
            r_word    <= '0;
        end else begin
            r_push <= 1'b0;
            if (baud_tick) begin
                // cnt restarts on every state change so each state measures from its own entry
                if (w_next != r_state || r_state == IDLE || r_state == BREAK || r_cnt == CNT_LAST)
                    r_cnt <= '0;
                else
                    r_cnt <= r_cnt + CNT_ONE;

                if (w_next != r_state)
                    r_bitcnt <= '0;
                else if (w_samp)
                    r_bitcnt <= r_bitcnt + BIT_ONE;

                case (r_state)
                    IDLE: if (!r_rxs) begin
                        r_par_en  <= (parity_mode == 2'd1) || (parity_mode == 2'd2);
                        r_par_odd <= (parity_mode == 2'd2);
                        r_perr    <= 1'b0;
                        r_ferr    <= 1'b0;
                    end
                    DATA:   if (w_samp) r_shift <= {r_rxs, r_shift[DATA_BITS-1:1]};
                    PARITY: if (w_samp) r_perr <= (^r_shift) ^ r_rxs ^ r_par_odd;
                    STOP: if (w_samp) begin
                        r_ferr <= w_stop_ferr;
                        if (r_bitcnt == STOP_LAST) begin
                            r_push <= 1'b1;
                            r_word <= {w_stop_ferr, r_perr, r_shift};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_full  = (r_level == LVL_FULL);
    assign w_empty = (r_level == '0);
    assign w_pop   = rd_en && !w_empty;
    assign w_wr    = r_push && (!w_full || rd_en);
    assign w_drop  = r_push && !w_wr;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_ONE;
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
            case ({w_wr, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase
            if (w_drop)
                r_overrun <= 1'b1;
            else if (ovr_clr)
                r_overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_word;
    end

    // Storage is unreset, so the head is masked to zero while empty
    assign w_head   = r_mem[r_rd_ptr];
    assign rx_data  = w_empty ? '0 : w_head[DATA_BITS-1:0];
    assign rx_perr  = !w_empty && w_head[DATA_BITS];
    assign rx_ferr  = !w_empty && w_head[DATA_BITS+1];
    assign rx_empty = w_empty;
    assign rx_full  = w_full;
    assign rx_level = r_level;
    assign overrun  = r_overrun;
    assign busy     = (r_state != IDLE);

endmodule
